// File: rtl/dadda_pkg.sv
// dadda_pkg
// Shared constants and the compile-time Dadda reduction schedule for the
// 8x8 unsigned multiplier.
//   MUL_W    : operand width
//   PROD_W   : product width (2*MUL_W), also the number of bit columns
//   MAX_H    : tallest partial-product column, which sizes the column arrays
//   dadda_d  : height limit that a given reduction stage reduces to
//   sched    : per stage and column, the incoming height or the FA/HA count
package dadda_pkg;

  localparam int MUL_W    = 8;
  localparam int PROD_W   = 2 * MUL_W;
  localparam int MAX_H    = MUL_W;
  localparam int N_STAGES = 4;

  // Selectors for sched()
  localparam int SCH_H  = 0;
  localparam int SCH_FA = 1;
  localparam int SCH_HA = 2;

  // Height limits of the four stages: 6, 4, 3, 2
  function automatic int dadda_d(input int s);
    case (s)
      0:       return 6;
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  // Partial-product column heights: 1,2,..,8,..,2,1 (column 15 is empty)
  function automatic int pp_height(input int c);
    if (c < MUL_W)           return c + 1;
    else if (c < PROD_W - 1) return PROD_W - 1 - c;
    else                     return 0;
  endfunction

  // Replays the reduction from the partial products up to stage s and
  // returns, for column c of that stage, its input height or the number of
  // full/half adders placed there. Columns are walked LSB first so that the
  // carries arriving from column c-1 count toward the height of column c.
  // Only the excess above the limit is removed: each FA removes two bits,
  // and a single leftover bit of excess costs one HA.
  function automatic int sched(input int s, input int c, input int what);
    int h  [PROD_W];
    int nh [PROD_W];
    int cin, e, fa, ha;
    for (int col = 0; col < PROD_W; col++) h[col] = pp_height(col);
    for (int st = 0; st <= s; st++) begin
      cin = 0;
      for (int col = 0; col < PROD_W; col++) begin
        if (st == s && col == c) begin
          e  = h[col] + cin - dadda_d(st);
          fa = (e > 0) ? e / 2 : 0;
          ha = (e > 0) ? e % 2 : 0;
          if (what == SCH_H)  return h[col];
          if (what == SCH_FA) return fa;
          return ha;
        end
        e       = h[col] + cin - dadda_d(st);
        fa      = (e > 0) ? e / 2 : 0;
        ha      = (e > 0) ? e % 2 : 0;
        nh[col] = h[col] - 2 * fa - ha + cin;
        cin     = fa + ha;
      end
      h = nh;
    end
    return 0;
  endfunction

endpackage

// File: rtl/dadda_fa.sv
// dadda_fa
// Full adder (3:2 compressor).
//   x, y, cin : input bits of equal weight
//   sum       : result bit, same weight
//   cout      : carry bit, next weight up
module dadda_fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/dadda_ha.sv
// dadda_ha
// Half adder (2:2 compressor).
//   x, y : input bits of equal weight
//   sum  : result bit, same weight
//   cout : carry bit, next weight up
module dadda_ha (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y;
  assign cout = x & y;

endmodule

// File: rtl/dadda_stage.sv
// dadda_stage
// One Dadda reduction stage. The FA/HA count of every column comes from the
// compile-time schedule in dadda_pkg, so each stage instance elaborates
// exactly the adders that its height limit needs.
//   STAGE : stage index 0..3 (height limits 6, 4, 3, 2)
//   col_i : bit columns entering the stage, [column][bit], unused bits are 0
//   col_o : bit columns leaving the stage, same layout
// Output column layout: untouched bits first, then this column's FA sums,
// then HA sums, then carries arriving from the column below.
module dadda_stage
  import dadda_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  logic [PROD_W-1:0][MAX_H-1:0] col_i,
  output logic [PROD_W-1:0][MAX_H-1:0] col_o
);

  // Carries produced in each column: FA carries first, then the HA carry
  logic [PROD_W-1:0][MAX_H-1:0] cy;

  for (genvar gc = 0; gc < PROD_W; gc++) begin : g_col
    localparam int H     = sched(STAGE, gc, SCH_H);
    localparam int FA    = sched(STAGE, gc, SCH_FA);
    localparam int HA    = sched(STAGE, gc, SCH_HA);
    localparam int USED  = 3 * FA + 2 * HA;
    localparam int PASS  = H - USED;
    localparam int CIN_N = (gc > 0) ? sched(STAGE, gc - 1, SCH_FA) + sched(STAGE, gc - 1, SCH_HA) : 0;
    localparam int OUT_H = PASS + FA + HA + CIN_N;

    for (genvar gk = 0; gk < FA; gk++) begin : g_fa
      dadda_fa u_fa (
        .x   (col_i[gc][3*gk]),
        .y   (col_i[gc][3*gk+1]),
        .cin (col_i[gc][3*gk+2]),
        .sum (col_o[gc][PASS+gk]),
        .cout(cy[gc][gk])
      );
    end

    for (genvar gk = 0; gk < HA; gk++) begin : g_ha
      dadda_ha u_ha (
        .x   (col_i[gc][3*FA+2*gk]),
        .y   (col_i[gc][3*FA+2*gk+1]),
        .sum (col_o[gc][PASS+FA+gk]),
        .cout(cy[gc][FA+gk])
      );
    end

    // Bits above the adders' inputs pass straight through
    for (genvar gp = 0; gp < PASS; gp++) begin : g_pass
      assign col_o[gc][gp] = col_i[gc][USED+gp];
    end

    for (genvar gj = 0; gj < CIN_N; gj++) begin : g_cin
      assign col_o[gc][PASS+FA+HA+gj] = cy[gc-1][gj];
    end

    for (genvar gz = OUT_H; gz < MAX_H; gz++) begin : g_zo
      assign col_o[gc][gz] = 1'b0;
    end

    for (genvar gz = FA + HA; gz < MAX_H; gz++) begin : g_zc
      assign cy[gc][gz] = 1'b0;
    end
  end

  // Empty slots of the column arrays are intentionally left unread
  logic unused_bits;
  assign unused_bits = ^{col_i, cy};

endmodule

// File: rtl/dadda_mul_8x8.sv
// dadda_mul_8x8
// Unsigned 8x8 multiplier: AND-array partial products, four-stage Dadda
// reduction (limits 6, 4, 3, 2) and a final 16-bit carry-propagate adder.
//   clock   : clocks out_q only
//   reset_n : asynchronous active-low reset, clears out_q
//   a, b    : unsigned operands
//   out     : combinational product a*b
//   out_q   : out registered on the rising edge of clock
module dadda_mul_8x8
  import dadda_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out,
  output logic [2*WIDTH-1:0] out_q
);

  logic [PROD_W-1:0][MAX_H-1:0] t0, t1, t2, t3, t4;
  logic [PROD_W-1:0]            row0, row1;

  // pp[i][j] lands in column i+j; within a column bits are packed by i,
  // starting from the smallest i that can reach that column.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ppa
    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_ppb
      localparam int C  = gi + gj;
      localparam int LO = (C >= WIDTH) ? C - WIDTH + 1 : 0;
      assign t0[C][gi-LO] = a[gi] & b[gj];
    end
  end

  for (genvar gc = 0; gc < PROD_W; gc++) begin : g_ppz
    localparam int PH = pp_height(gc);
    for (genvar gk = PH; gk < MAX_H; gk++) begin : g_z
      assign t0[gc][gk] = 1'b0;
    end
  end

  dadda_stage #(.STAGE(0)) u_st0 (.col_i(t0), .col_o(t1));
  dadda_stage #(.STAGE(1)) u_st1 (.col_i(t1), .col_o(t2));
  dadda_stage #(.STAGE(2)) u_st2 (.col_i(t2), .col_o(t3));
  dadda_stage #(.STAGE(3)) u_st3 (.col_i(t3), .col_o(t4));

  // At most two bits remain per column; gather them into two addend rows
  for (genvar gc = 0; gc < PROD_W; gc++) begin : g_rows
    assign row0[gc] = t4[gc][0];
    assign row1[gc] = t4[gc][1];
  end

  // The sum can never exceed 16 bits, so the carry out is simply dropped
  assign out = row0 + row1;

  logic unused_t4;
  assign unused_t4 = ^t4;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else          out_q <= out;
  end

endmodule

// File: tb/tb_dadda_mul_8x8.sv
module tb_dadda_mul_8x8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] out;
  logic [15:0] out_q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] exp_p;
  } vec_t;

  dadda_mul_8x8 dut (
    .clock  (clock),
    .reset_n(reset_n),
    .a      (a),
    .b      (b),
    .out    (out),
    .out_q  (out_q)
  );

  always #5 clock = ~clock;

  // Reference: plain integer multiplication of the unsigned operands
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%04h) expected %0d (0x%04h)", name, act, act, exp_v, exp_v);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  vec_t tbl[9];

  initial begin
    logic [15:0] prev_exp;
    logic [15:0] cur_exp;
    int          sweep_err;

    tbl[0] = '{8'd0,   8'd0,   16'd0};
    tbl[1] = '{8'd0,   8'd255, 16'd0};
    tbl[2] = '{8'd255, 8'd255, 16'hFE01};
    tbl[3] = '{8'd255, 8'd1,   16'd255};
    tbl[4] = '{8'd1,   8'd255, 16'd255};
    tbl[5] = '{8'd128, 8'd2,   16'd256};
    tbl[6] = '{8'd170, 8'd85,  16'd14450};
    tbl[7] = '{8'd85,  8'd170, 16'd14450};
    tbl[8] = '{8'd16,  8'd16,  16'd256};

    // Reset behaviour: out is live, out_q held at zero
    reset_n = 1'b0;
    a = 8'd12;
    b = 8'd13;
    #1;
    check("reset_out", out, 16'd156);
    check("reset_out_q", out_q, 16'd0);
    @(posedge clock);
    #1;
    check("reset_hold_out_q", out_q, 16'd0);

    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("release_out_q", out_q, 16'd156);

    // Asynchronous reset in the middle of the low phase
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_q", out_q, 16'd0);
    check("async_rst_out", out, 16'd156);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed table: out before the edge, out_q after it
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      a = tbl[i].va;
      b = tbl[i].vb;
      #4;
      check($sformatf("tbl%0d_out %0d*%0d", i, tbl[i].va, tbl[i].vb), out, tbl[i].exp_p);
      @(posedge clock);
      #1;
      check($sformatf("tbl%0d_out_q", i), out_q, tbl[i].exp_p);
    end

    // 100 vectors: walking-one a, walking-one b, then random
    prev_exp = '0;
    for (int i = 0; i < 100; i++) begin
      logic [7:0] va, vb;
      @(negedge clock);
      if (i > 0) check($sformatf("stream%0d_out_q", i - 1), out_q, prev_exp);
      if (i < 8) begin
        va = 8'd1 << i;
        vb = 8'($urandom_range(0, 255));
      end else if (i < 16) begin
        va = 8'($urandom_range(0, 255));
        vb = 8'd1 << (i - 8);
      end else begin
        va = 8'($urandom_range(0, 255));
        vb = 8'($urandom_range(0, 255));
      end
      a = va;
      b = vb;
      cur_exp = ref_mul(va, vb);
      #4;
      check($sformatf("stream%0d_out %0d*%0d", i, va, vb), out, cur_exp);
      prev_exp = cur_exp;
    end
    @(negedge clock);
    check("stream99_out_q", out_q, prev_exp);

    // Exhaustive combinational sweep, reported as one comparison
    sweep_err = 0;
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        a = 8'(x);
        b = 8'(y);
        #1;
        if (out !== ref_mul(8'(x), 8'(y))) sweep_err++;
      end
    end
    n_cmp++;
    if (sweep_err != 0) begin
      n_bad++;
      $display("FAIL sweep: %0d wrong products, required 0", sweep_err);
    end else begin
      $display("ok   sweep: 65536 products");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
